// File: rtl/symbol_sched_pkg.sv
// Shared widths, symbol size and FSM state encoding for the symbol draw scheduler.
package symbol_sched_pkg;

    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int COL_W      = 3;
    localparam int SYM_PIXELS = 50;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/symbol_offset_rom.sv
// Combinational diamond-symbol offset table: pixel index -> (xoff, yoff), raster order.
import symbol_sched_pkg::*;

module symbol_offset_rom (
    input  logic [IDX_W-1:0] idx,
    output logic [3:0]       xoff,
    output logic [3:0]       yoff
);

    logic [IDX_W-1:0] row_base;
    logic [3:0]       row_xstart;

    // Each row is a contiguous x run; locate the row, then offset from its left edge.
    always_comb begin
        row_base   = 6'd0;
        row_xstart = 4'd8;
        yoff       = 4'd3;
        if (idx < 6'd1) begin
            row_base = 6'd0;  row_xstart = 4'd8; yoff = 4'd3;
        end else if (idx < 6'd4) begin
            row_base = 6'd1;  row_xstart = 4'd7; yoff = 4'd4;
        end else if (idx < 6'd9) begin
            row_base = 6'd4;  row_xstart = 4'd6; yoff = 4'd5;
        end else if (idx < 6'd16) begin
            row_base = 6'd9;  row_xstart = 4'd5; yoff = 4'd6;
        end else if (idx < 6'd25) begin
            row_base = 6'd16; row_xstart = 4'd4; yoff = 4'd7;
        end else if (idx < 6'd34) begin
            row_base = 6'd25; row_xstart = 4'd4; yoff = 4'd8;
        end else if (idx < 6'd41) begin
            row_base = 6'd34; row_xstart = 4'd5; yoff = 4'd9;
        end else if (idx < 6'd46) begin
            row_base = 6'd41; row_xstart = 4'd6; yoff = 4'd10;
        end else if (idx < 6'd49) begin
            row_base = 6'd46; row_xstart = 4'd7; yoff = 4'd11;
        end else if (idx < 6'd50) begin
            row_base = 6'd49; row_xstart = 4'd8; yoff = 4'd12;
        end else begin
            row_base = idx;   row_xstart = 4'd8; yoff = 4'd3;
        end
        xoff = row_xstart + 4'(idx - row_base);
    end

endmodule

// File: rtl/symbol_draw_scheduler.sv
// Round-robin sharing of one VGA plot port among NREQ diamond-symbol requesters.
// Optional erase requests are enabled by defining SYMBOL_SCHED_ERASE_EN.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate from rr_ptr and latch the winner
// DRAW  | plot one symbol pixel per cycle, idx 0..49
// DONE  | pulse done for the owner, advance rr_ptr
import symbol_sched_pkg::*;

module symbol_draw_scheduler #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*X_W-1:0]   req_x,
    input  logic [NREQ*Y_W-1:0]   req_y,
    input  logic [NREQ*COL_W-1:0] req_colour,
`ifdef SYMBOL_SCHED_ERASE_EN
    input  logic [NREQ-1:0]       req_erase,
`endif
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  plot,
    output logic [X_W-1:0]        xout,
    output logic [Y_W-1:0]        yout,
    output logic [COL_W-1:0]      colour
);

    localparam int PTR_W = $clog2(NREQ);

    sched_state_t     state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic [X_W-1:0]   x_lat;
    logic [Y_W-1:0]   y_lat;
    logic [COL_W-1:0] col_lat;
    logic [3:0]       xoff;
    logic [3:0]       yoff;
    logic [NREQ-1:0]  owner_oh;
    logic             found;
    int               cand;
`ifdef SYMBOL_SCHED_ERASE_EN
    logic             erase_lat;
`endif

    symbol_offset_rom u_rom (
        .idx  (idx),
        .xoff (xoff),
        .yoff (yoff)
    );

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                pick  = PTR_W'(cand);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            idx       <= '0;
            x_lat     <= '0;
            y_lat     <= '0;
            col_lat   <= '0;
`ifdef SYMBOL_SCHED_ERASE_EN
            erase_lat <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= pick;
                        x_lat     <= req_x[pick*X_W +: X_W];
                        y_lat     <= req_y[pick*Y_W +: Y_W];
                        col_lat   <= req_colour[pick*COL_W +: COL_W];
`ifdef SYMBOL_SCHED_ERASE_EN
                        erase_lat <= req_erase[pick];
`endif
                        idx       <= '0;
                        state     <= DRAW;
                    end
                end
                DRAW: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(SYM_PIXELS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_oh = NREQ'(1) << owner;
    assign busy     = (state != IDLE);
    assign plot     = (state == DRAW);
    assign grant    = busy ? owner_oh : '0;
    assign done     = (state == DONE) ? owner_oh : '0;
    assign xout     = plot ? x_lat + {4'b0, xoff} : '0;
    assign yout     = plot ? y_lat + {3'b0, yoff} : '0;
`ifdef SYMBOL_SCHED_ERASE_EN
    assign colour   = (plot && !erase_lat) ? col_lat : '0;
`else
    assign colour   = plot ? col_lat : '0;
`endif

endmodule

// File: tb/tb_symbol_draw_scheduler.sv
// Directed self-checking bench for symbol_draw_scheduler with NREQ=2.
module tb_symbol_draw_scheduler;

    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_x;
    logic [13:0] req_y;
    logic [5:0]  req_colour;
`ifdef SYMBOL_SCHED_ERASE_EN
    logic [1:0]  req_erase;
`endif
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        busy;
    logic        plot;
    logic [7:0]  xout;
    logic [6:0]  yout;
    logic [2:0]  colour;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_xo [50];
    int exp_yo [50];

    symbol_draw_scheduler #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
`ifdef SYMBOL_SCHED_ERASE_EN
        .req_erase  (req_erase),
`endif
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .plot       (plot),
        .xout       (xout),
        .yout       (yout),
        .colour     (colour)
    );

    always #5 clk = ~clk;

    // Reference mask from the row table: row y = r+3 spans x = lo..16-lo.
    task automatic build_mask();
        int n;
        int lo;
        n = 0;
        for (int r = 0; r < 10; r++) begin
            lo = (r < 5) ? 8 - r : r - 1;
            for (int xx = lo; xx <= 16 - lo; xx++) begin
                exp_xo[n] = xx;
                exp_yo[n] = r + 3;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; req_x = '0; req_y = '0; req_colour = '0;
`ifdef SYMBOL_SCHED_ERASE_EN
        req_erase = 2'b00;
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, plot, grant, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy=%b plot=%b grant=%b done=%b, want all 0", busy, plot, grant, done);
        end
        n_cmp++;
        if ({xout, yout, colour} !== 18'b0) begin
            n_bad++;
            $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d, want 0", xout, yout, colour);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] ex;
        logic [6:0] ey;
        req = 2'b01; req_x[7:0] = 8'd20; req_y[6:0] = 7'd30; req_colour[2:0] = 3'b110;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ex = 8'(20 + exp_xo[i]);
            ey = 7'(30 + exp_yo[i]);
            n_cmp++;
            if ({plot, grant, done, xout, yout, colour} !== {1'b1, 2'b01, 2'b00, ex, ey, 3'b110}) begin
                n_bad++;
                $display("FAIL single_px[%0d]: got p=%b g=%b d=%b (%0d,%0d) c=%0d, want p=1 g=01 d=00 (%0d,%0d) c=6",
                         i, plot, grant, done, xout, yout, colour, ex, ey);
            end
            if (i == 0) begin
                n_cmp++;
                if ({xout, yout} !== {8'd28, 7'd33}) begin
                    n_bad++;
                    $display("FAIL single_first: got (%0d,%0d), want (28,33)", xout, yout);
                end
            end
            if (i == 49) begin
                n_cmp++;
                if ({xout, yout} !== {8'd28, 7'd42}) begin
                    n_bad++;
                    $display("FAIL single_last: got (%0d,%0d), want (28,42)", xout, yout);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({plot, done, grant, busy, xout, colour} !== {1'b0, 2'b01, 2'b01, 1'b1, 8'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL single_done: got p=%b d=%b g=%b busy=%b x=%0d c=%0d, want p=0 d=01 g=01 busy=1 x=0 c=0",
                     plot, done, grant, busy, xout, colour);
        end
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, grant} !== 5'b0) begin
            n_bad++;
            $display("FAIL single_idle: got busy=%b d=%b g=%b, want 0", busy, done, grant);
        end
    endtask

    task automatic test_back_to_back();
        int         w;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic [1:0] eg;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 2'b11;
        req_x = {8'd100, 8'd10}; req_y = {7'd50, 7'd10}; req_colour = {3'd2, 3'd1};
        for (int d = 0; d < 4; d++) begin
            w  = d % 2;
            eg = 2'(1 << w);
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                ex = 8'((w == 0 ? 10 : 100) + exp_xo[i]);
                ey = 7'((w == 0 ? 10 : 50) + exp_yo[i]);
                ec = (w == 0) ? 3'd1 : 3'd2;
                n_cmp++;
                if ({plot, grant, xout, yout, colour} !== {1'b1, eg, ex, ey, ec}) begin
                    n_bad++;
                    $display("FAIL b2b_px[%0d.%0d]: got p=%b g=%b (%0d,%0d) c=%0d, want p=1 g=%b (%0d,%0d) c=%0d",
                             d, i, plot, grant, xout, yout, colour, eg, ex, ey, ec);
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({plot, done, grant} !== {1'b0, eg, eg}) begin
                n_bad++;
                $display("FAIL b2b_done[%0d]: got p=%b d=%b g=%b, want p=0 d=%b g=%b", d, plot, done, grant, eg, eg);
            end
            if (d == 3) req = 2'b00;
            @(negedge clk);
            n_cmp++;
            if ({busy, plot, grant, done} !== 6'b0) begin
                n_bad++;
                $display("FAIL b2b_idle[%0d]: got busy=%b p=%b g=%b d=%b, want 0", d, busy, plot, grant, done);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ex;
        logic [6:0] ey;
        req = 2'b01; req_x[7:0] = 8'd250; req_y[6:0] = 7'd120; req_colour[2:0] = 3'b011;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) req = 2'b00;
            ex = 8'((250 + exp_xo[i]) % 256);
            ey = 7'((120 + exp_yo[i]) % 128);
            n_cmp++;
            if ({plot, grant, xout, yout, colour} !== {1'b1, 2'b01, ex, ey, 3'b011}) begin
                n_bad++;
                $display("FAIL wrap_px[%0d]: got p=%b g=%b (%0d,%0d) c=%0d, want p=1 g=01 (%0d,%0d) c=3",
                         i, plot, grant, xout, yout, colour, ex, ey);
            end
            if (i == 0 || i == 16 || i == 24) begin
                n_cmp++;
                if ((i == 0  && {xout, yout} !== {8'd2,   7'd123}) ||
                    (i == 16 && {xout, yout} !== {8'd254, 7'd127}) ||
                    (i == 24 && {xout, yout} !== {8'd6,   7'd127})) begin
                    n_bad++;
                    $display("FAIL wrap_point[%0d]: got (%0d,%0d)", i, xout, yout);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b01) begin
            n_bad++;
            $display("FAIL wrap_done_after_drop: got d=%b, want 01", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req = 2'b10; req_x = {8'd40, 8'd60}; req_y = {7'd20, 7'd70}; req_colour = {3'd5, 3'd4};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        n_cmp++;
        if ({plot, grant} !== {1'b1, 2'b10}) begin
            n_bad++;
            $display("FAIL rstmid_pre: got p=%b g=%b, want p=1 g=10", plot, grant);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({plot, busy, done, grant, xout, yout, colour} !== 24'b0) begin
            n_bad++;
            $display("FAIL rstmid_after: got p=%b busy=%b d=%b g=%b x=%0d y=%0d c=%0d, want 0",
                     plot, busy, done, grant, xout, yout, colour);
        end
        reset = 1'b0;
        req = 2'b11;
        @(negedge clk);
        n_cmp++;
        if ({plot, grant, xout, yout, colour} !== {1'b1, 2'b01, 8'd68, 7'd73, 3'd4}) begin
            n_bad++;
            $display("FAIL rstmid_regrant: got p=%b g=%b (%0d,%0d) c=%0d, want p=1 g=01 (68,73) c=4",
                     plot, grant, xout, yout, colour);
        end
        req = 2'b01;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (done !== 2'b01) begin
            n_bad++;
            $display("FAIL rstmid_done: got d=%b, want 01", done);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

`ifdef SYMBOL_SCHED_ERASE_EN
    task automatic test_erase();
        req = 2'b01; req_erase = 2'b01; req_x[7:0] = 8'd5; req_y[6:0] = 7'd5; req_colour[2:0] = 3'b111;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({plot, colour, xout} !== {1'b1, 3'b000, 8'(5 + exp_xo[i])}) begin
                n_bad++;
                $display("FAIL erase_px[%0d]: got p=%b c=%0d x=%0d, want p=1 c=0 x=%0d", i, plot, colour, xout, 5 + exp_xo[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b01) begin
            n_bad++;
            $display("FAIL erase_done: got d=%b, want 01", done);
        end
        req = 2'b00; req_erase = 2'b00;
        @(negedge clk);
    endtask
`endif

    initial begin
        build_mask();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef SYMBOL_SCHED_ERASE_EN
        test_erase();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
